// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial adder sequencer.
// The producer/consumer side is the master; the sequencer is the slave.
interface nibble_serial_adder_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Drives an external combinational 4-bit adder one nibble per clock, LSB nibble
// first, chaining the carry through a register and assembling the wide sum.
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  nibble_serial_adder_ctrl_if.slave   bus,
  output logic [3:0]                  add_x,
  output logic [3:0]                  add_y,
  output logic                        add_cin,
  input  logic [3:0]                  add_s,
  input  logic                        add_cout,
  output logic                        busy
);
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state;
  state_t                   state_next;
  logic [IDX_W-1:0]         idx;
  logic [NIBBLES-1:0][3:0]  a_reg;
  logic [NIBBLES-1:0][3:0]  b_reg;
  logic [NIBBLES-1:0][3:0]  sum_reg;
  logic                     carry_reg;
  logic                     cout_reg;
  logic                     accept;

  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    add_x         = 4'd0;
    add_y         = 4'd0;
    add_cin       = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        add_x   = a_reg[idx];
        add_y   = b_reg[idx];
        add_cin = carry_reg;
        if (idx == LAST) state_next = DONE;
      end
      DONE: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers; the adder result is captured on the same edge it is driven for.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_reg     <= bus.in_a;
        b_reg     <= bus.in_b;
        carry_reg <= bus.in_cin;
        idx       <= '0;
        sum_reg   <= '0;
      end else if (state == RUN) begin
        sum_reg[idx] <= add_s;
        carry_reg    <= add_cout;
        if (idx == LAST) cout_reg <= add_cout;
        else             idx      <= idx + 1'b1;
      end
    end
  end

  assign bus.out_sum  = sum_reg;
  assign bus.out_cout = cout_reg;
endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that wraps the team's combinational 4-bit binary adder (x, y, cin -> s, cout) to add wide operands one nibble per clock, least-significant nibble first.
- Feeds the adder's operand and carry inputs, consumes its sum and carry outputs, and registers the carry between nibbles.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair offered
in_ready  output  1  block can accept operands
in_a  input  W  operand A
in_b  input  W  operand B
in_cin  input  1  carry-in for nibble 0
add_x  output  4  to adder x
add_y  output  4  to adder y
add_cin  output  1  to adder cin
add_s  input  4  from adder s (combinational, same cycle)
add_cout  input  1  from adder cout (combinational, same cycle)
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_sum  output  W  A+B+cin modulo 2^W
out_cout  output  1  carry out of the top nibble
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, sampled on the rising edge; it overrides all other inputs.
- Reset state: state=IDLE, idx=0, a_reg=b_reg=0, carry_reg=0, sum_reg=0, cout_reg=0.
- Outputs after reset: in_ready=1, out_valid=0, out_sum=0, out_cout=0, busy=0, add_x=0, add_y=0, add_cin=0.

FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - If in_valid, on the edge: latch in_a into a_reg and in_b into b_reg, carry_reg<=in_cin, idx<=0, sum_reg<=0, go to RUN.
- RUN:
  - in_ready=0.
  - Combinational drives: add_x=a_reg[4*idx+:4], add_y=b_reg[4*idx+:4], add_cin=carry_reg.
  - Each edge: sum_reg[4*idx+:4]<=add_s, carry_reg<=add_cout.
  - If idx==NIBBLES-1: cout_reg<=add_cout and go to DONE. Otherwise idx<=idx+1.
- DONE:
  - out_valid=1; out_sum=sum_reg and out_cout=cout_reg, both stable until the handshake.
  - On out_valid&&out_ready: go to IDLE.
  - No input is accepted in the handshake cycle; the next accept is possible at the earliest one cycle later.
- Outside RUN, add_x, add_y and add_cin are driven to 0.

Timing and arithmetic:
- Latency: accept edge E0; nibbles are processed on edges E1..E_NIBBLES; out_valid is high in the cycle after E_NIBBLES.
- Throughput: one operation per NIBBLES+2 cycles with out_ready held high.
- Arithmetic is unsigned. Carry chain: carry out of nibble i is carry in of nibble i+1.
- out_cout is the true carry out of the W-bit sum. No overflow flag.

Boundary conditions:
- Reset mid-RUN or in DONE: partial or pending result is discarded; all outputs return to reset values on the next cycle.
- in_valid while not in IDLE: ignored; the producer must hold its data until in_ready.
- out_ready while not in DONE: ignored.
- NIBBLES=1: a single RUN cycle, then DONE.
- idx width is clog2(NIBBLES), minimum 1.

Test Plan:
1. NIBBLES=4, in_a=0x1234, in_b=0x4321, in_cin=0, out_ready=1 -> out_sum=0x5555, out_cout=0; out_valid rises exactly 4 edges after the accept edge; add_x follows 4,3,2,1 over the RUN cycles.
2. in_a=0xFFFF, in_b=0x0001, in_cin=0 -> add_cin is 0,1,1,1 across the RUN cycles; out_sum=0x0000, out_cout=1.
3. in_a=0xFFFF, in_b=0x0000, in_cin=1 -> out_sum=0x0000, out_cout=1. Then in_a=0x8000, in_b=0x8000, in_cin=0 -> out_sum=0x0000, out_cout=1.
4. Backpressure: result 0xA5A5 (0x5050+0x5555) with out_ready low for 3 cycles -> out_valid, out_sum and out_cout stay stable; in_ready=0 and busy=1 throughout; IDLE is reached the cycle after out_ready rises.
5. Assert rst after 2 RUN edges of 0x1111+0x2222 -> next cycle: in_ready=1, out_valid=0, out_sum=0, busy=0. A new 0x0001+0x0001 then yields 0x0002 with cout=0.
6. NIBBLES=1: in_a=0xF, in_b=0x1, in_cin=0 -> out_sum=0x0, out_cout=1, out_valid 1 edge after the accept edge. Back-to-back in_valid held high gives one accept per 3 cycles.
